// File: rtl/imem_pkg.sv
// Shared constants, FSM state type and fault-cause helper for the loadable instruction memory.
package imem_pkg;

    localparam logic [31:0] NOP = 32'h0000_0000;

    typedef enum logic {
        CLEAR,
        RUN
    } imem_state_t;

    typedef enum logic [1:0] {
        FC_NONE,
        FC_MISALIGN,
        FC_RANGE
    } fault_cause_t;

    function automatic fault_cause_t fault_cause(input logic [1:0] byte_off,
                                                 input logic       out_of_range);
        if (byte_off != 2'b00) return FC_MISALIGN;
        if (out_of_range)      return FC_RANGE;
        return FC_NONE;
    endfunction

endpackage

// File: rtl/imem_array.sv
// Single-write, single-synchronous-read word array; a read and write to the same word
// in one cycle returns the old content.
module imem_array #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 128,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
        if (rd_en) rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/imem_fetch.sv
// IF-stage instruction memory: zero-fills after reset, then serves registered fetches and
// accepts program loads. Define IMEM_PARITY_EN to store and check even parity per word.
//
// state | meaning
// CLEAR | writing NOP to word clr_cnt, loads and fetches refused
// RUN   | loads accepted every cycle, fetches served
module imem_fetch
    import imem_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 128
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [WIDTH-1:0]         pc,
    input  logic                     fetch_en,
    input  logic                     stall,
    input  logic                     flush,
    output logic [WIDTH-1:0]         instruction,
    output logic                     instr_valid,
    output logic                     fault,
    input  logic                     load_valid,
    output logic                     load_ready,
    input  logic [$clog2(DEPTH)-1:0] load_addr,
    input  logic [WIDTH-1:0]         load_data
`ifdef IMEM_PARITY_EN
    ,
    output logic                     parity_err
`endif
);

    localparam int ADDR_W = $clog2(DEPTH);
`ifdef IMEM_PARITY_EN
    localparam int MEM_W = WIDTH + 1;
`else
    localparam int MEM_W = WIDTH;
`endif

    imem_state_t       state;
    logic [ADDR_W-1:0] clr_cnt;
    logic              nop_q;
    logic              valid_q;
    logic              fault_q;

    logic              oor;
    logic              addr_flt;
    logic              fetch_go;
    logic              rd_en;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [ADDR_W-1:0] rd_addr;
    logic [WIDTH-1:0]  wr_word;
    logic [WIDTH-1:0]  rd_word;
    logic [MEM_W-1:0]  wr_data;
    logic [MEM_W-1:0]  rd_data;
    logic              par_bad;

    // DEPTH is a power of two, so any set bit above the word index is out of range
    assign oor      = |pc[WIDTH-1:ADDR_W+2];
    assign addr_flt = (fault_cause(pc[1:0], oor) != FC_NONE);
    assign fetch_go = (state == RUN) && fetch_en && !stall && !flush;
    assign rd_en    = fetch_go && !addr_flt;
    assign rd_addr  = pc[ADDR_W+1:2];

    assign wr_en   = (state == CLEAR) || load_valid;
    assign wr_addr = (state == CLEAR) ? clr_cnt : load_addr;
    assign wr_word = (state == CLEAR) ? WIDTH'(NOP) : load_data;

`ifdef IMEM_PARITY_EN
    assign wr_data    = {^wr_word, wr_word};
    assign rd_word    = rd_data[WIDTH-1:0];
    assign par_bad    = !nop_q && (^rd_data);
    assign parity_err = par_bad && valid_q;
`else
    assign wr_data = wr_word;
    assign rd_word = rd_data;
    assign par_bad = 1'b0;
`endif

    // The array's read register doubles as the instruction data register; nop_q masks it
    assign instruction = (nop_q || par_bad) ? WIDTH'(NOP) : rd_word;
    assign instr_valid = valid_q;
    assign fault       = fault_q || (par_bad && valid_q);

    imem_array #(
        .DATA_W (MEM_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_array (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_en   (rd_en),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= CLEAR;
            clr_cnt    <= '0;
            load_ready <= 1'b0;
            nop_q      <= 1'b1;
            valid_q    <= 1'b0;
            fault_q    <= 1'b0;
        end else begin
            case (state)
                CLEAR: begin
                    clr_cnt <= clr_cnt + ADDR_W'(1);
                    if (clr_cnt == ADDR_W'(DEPTH - 1)) begin
                        state      <= RUN;
                        load_ready <= 1'b1;
                    end
                end
                RUN: load_ready <= 1'b1;
                default: state <= CLEAR;
            endcase

            if (flush) begin
                nop_q   <= 1'b1;
                valid_q <= 1'b0;
                fault_q <= 1'b0;
            end else if (stall) begin
                nop_q   <= nop_q;
            end else if (fetch_go) begin
                nop_q   <= addr_flt;
                valid_q <= 1'b1;
                fault_q <= addr_flt;
            end else begin
                valid_q <= 1'b0;
                fault_q <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_imem_fetch.sv
// Directed bench for imem_fetch: reset/clear timing, vector table of fetch/load/stall/flush
// cases, and reset-restart sequences.
module tb_imem_fetch;
    localparam int WIDTH = 32;
    localparam int DEPTH = 128;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] pc = '0;
    logic        fetch_en = 1'b0;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic [31:0] instruction;
    logic        instr_valid;
    logic        fault;
    logic        load_valid = 1'b0;
    logic        load_ready;
    logic [6:0]  load_addr = '0;
    logic [31:0] load_data = '0;
`ifdef IMEM_PARITY_EN
    logic        parity_err;
`endif

    int n_cmp = 0;
    int n_err = 0;

    imem_fetch #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst         (rst),
        .pc          (pc),
        .fetch_en    (fetch_en),
        .stall       (stall),
        .flush       (flush),
        .instruction (instruction),
        .instr_valid (instr_valid),
        .fault       (fault),
        .load_valid  (load_valid),
        .load_ready  (load_ready),
        .load_addr   (load_addr),
        .load_data   (load_data)
`ifdef IMEM_PARITY_EN
        ,
        .parity_err  (parity_err)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        lv;
        logic [6:0]  la;
        logic [31:0] ld;
        logic        fe;
        logic        st;
        logic        fl;
        logic [31:0] pc;
        logic [31:0] ei;
        logic        ev;
        logic        ef;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic lv, input logic [6:0] la, input logic [31:0] ld,
                                input logic fe, input logic st, input logic fl,
                                input logic [31:0] p, input logic [31:0] ei,
                                input logic ev, input logic ef);
        vec_t v;
        v.lv = lv; v.la = la; v.ld = ld; v.fe = fe; v.st = st; v.fl = fl;
        v.pc = p;  v.ei = ei; v.ev = ev; v.ef = ef;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Counts CLEAR cycles after reset release: load_ready must stay low for DEPTH-1 edges
    task automatic wait_clear(input string tag);
        int bad;
        bad = 0;
        for (int i = 1; i < DEPTH; i++) begin
            tick();
            if (load_ready || instr_valid) bad++;
        end
        chk({tag, "_clear_low"}, bad, 0);
        tick();
        chk({tag, "_ready_rise"}, {31'b0, load_ready}, 1);
        chk({tag, "_valid_clear"}, {31'b0, instr_valid}, 0);
    endtask

    initial begin
        // stall/pc rows track the stall window: output holds while pc walks ahead
        vecs.push_back(mk(0, 0, 0,            1, 0, 0, 32'h10,  32'h0,        1, 0));
        vecs.push_back(mk(1, 3, 32'h04400800, 0, 0, 0, 32'h0,   32'h0,        0, 0));
        vecs.push_back(mk(0, 0, 0,            1, 0, 0, 32'h0C,  32'h04400800, 1, 0));
        vecs.push_back(mk(1, 6, 32'h11112222, 1, 1, 0, 32'h10,  32'h04400800, 1, 0));
        vecs.push_back(mk(0, 0, 0,            1, 1, 0, 32'h14,  32'h04400800, 1, 0));
        vecs.push_back(mk(0, 0, 0,            1, 1, 0, 32'h18,  32'h04400800, 1, 0));
        vecs.push_back(mk(0, 0, 0,            1, 0, 0, 32'h18,  32'h11112222, 1, 0));
        vecs.push_back(mk(0, 0, 0,            1, 0, 0, 32'h0C,  32'h04400800, 1, 0));
        vecs.push_back(mk(0, 0, 0,            1, 1, 1, 32'h0C,  32'h0,        0, 0));
        vecs.push_back(mk(0, 0, 0,            1, 0, 0, 32'h202, 32'h0,        1, 1));
        vecs.push_back(mk(0, 0, 0,            1, 0, 0, 32'h200, 32'h0,        1, 1));
        vecs.push_back(mk(0, 0, 0,            0, 0, 0, 32'h0C,  32'h0,        0, 0));
        vecs.push_back(mk(1, 5, 32'hDEADBEEF, 1, 0, 0, 32'h14,  32'h0,        1, 0));
        vecs.push_back(mk(0, 0, 0,            1, 0, 0, 32'h14,  32'hDEADBEEF, 1, 0));
        vecs.push_back(mk(0, 0, 0,            1, 0, 0, 32'h1FC, 32'h0,        1, 0));
        vecs.push_back(mk(0, 0, 0,            1, 0, 0, 32'h0C,  32'h04400800, 1, 0));
        vecs.push_back(mk(0, 0, 0,            0, 0, 0, 32'h14,  32'h04400800, 0, 0));
        vecs.push_back(mk(0, 0, 0,            1, 0, 0, 32'h0D,  32'h0,        1, 1));
        vecs.push_back(mk(0, 0, 0,            1, 1, 0, 32'h0C,  32'h0,        1, 1));
        vecs.push_back(mk(0, 0, 0,            1, 0, 1, 32'h0C,  32'h0,        0, 0));
        vecs.push_back(mk(0, 0, 0,            1, 0, 0, 32'h14,  32'hDEADBEEF, 1, 0));

        // reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_instr", instruction, 32'h0);
        chk("rst_valid", {31'b0, instr_valid}, 0);
        chk("rst_fault", {31'b0, fault}, 0);
        chk("rst_ready", {31'b0, load_ready}, 0);
`ifdef IMEM_PARITY_EN
        chk("rst_perr", {31'b0, parity_err}, 0);
`endif

        // fetch requests during CLEAR must be ignored
        fetch_en = 1'b1;
        pc = 32'h10;
        rst = 1'b1;
        wait_clear("init");

        for (int i = 0; i < vecs.size(); i++) begin
            load_valid = vecs[i].lv;
            load_addr  = vecs[i].la;
            load_data  = vecs[i].ld;
            fetch_en   = vecs[i].fe;
            stall      = vecs[i].st;
            flush      = vecs[i].fl;
            pc         = vecs[i].pc;
            tick();
            chk($sformatf("vec%0d_instr", i), instruction, vecs[i].ei);
            chk($sformatf("vec%0d_valid", i), {31'b0, instr_valid}, {31'b0, vecs[i].ev});
            chk($sformatf("vec%0d_fault", i), {31'b0, fault}, {31'b0, vecs[i].ef});
`ifdef IMEM_PARITY_EN
            chk($sformatf("vec%0d_perr", i), {31'b0, parity_err}, 0);
`endif
        end
        load_valid = 1'b0;
        stall = 1'b0;
        flush = 1'b0;
        fetch_en = 1'b0;

        // asynchronous reset in RUN clears outputs immediately
        rst = 1'b0;
        #1;
        chk("runrst_instr", instruction, 32'h0);
        chk("runrst_valid", {31'b0, instr_valid}, 0);
        chk("runrst_ready", {31'b0, load_ready}, 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        wait_clear("runrst");

        // reset part-way through CLEAR restarts the full zero-fill
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (50) tick();
        rst = 1'b0;
        #1;
        chk("midclr_ready", {31'b0, load_ready}, 0);
        tick();
        rst = 1'b1;
        wait_clear("midclr");

        // words loaded before reset are gone
        fetch_en = 1'b1;
        pc = 32'h0C;
        tick();
        chk("lost_instr", instruction, 32'h0);
        chk("lost_valid", {31'b0, instr_valid}, 1);
        chk("lost_fault", {31'b0, fault}, 0);

`ifdef IMEM_PARITY_EN
        dut.u_array.mem[5][0] = ~dut.u_array.mem[5][0];
        pc = 32'h14;
        tick();
        chk("par_instr", instruction, 32'h0);
        chk("par_fault", {31'b0, fault}, 1);
        chk("par_perr", {31'b0, parity_err}, 1);
        chk("par_valid", {31'b0, instr_valid}, 1);
        pc = 32'h0C;
        tick();
        chk("par_clean", {31'b0, parity_err}, 0);
`endif
        fetch_en = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/imem_fetch.md
# imem_fetch

Parametrised, loadable instruction memory for the MIPS pipeline's IF stage; successor to the fixed-program instruction memory. It holds DEPTH words, serves one registered fetch per cycle with stall/flush control and address-fault detection, and accepts program words through a valid/ready load port. After reset it zero-fills itself, so every word decodes as NOP before any program load.

## Interface
- WIDTH, 32, instruction and PC width in bits
- DEPTH, 128, words stored (power of two, ≥4); ADDR_W = log2(DEPTH) derived locally

- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset
- pc  in  WIDTH  byte address of fetch
- fetch_en  in  1  fetch request this cycle
- stall  in  1  hold output register
- flush  in  1  squash next output to NOP
- instruction  out  WIDTH  fetched word (registered)
- instr_valid  out  1  instruction is a live fetch result
- fault  out  1  fetched pc was misaligned or out of range
- load_valid  in  1  load word offered
- load_ready  out  1  load word accepted when high with load_valid
- load_addr  in  ADDR_W  word index to write
- load_data  in  WIDTH  word to write
- parity_err  out  1  read-word parity mismatch (present only with IMEM_PARITY_EN)

## Operation
- FSM states: CLEAR, RUN. Reset enters CLEAR with clr_cnt=0.
- CLEAR: write NOP (all-zero) to word clr_cnt each cycle, increment; after word DEPTH-1, go to RUN. load_ready=0, instr_valid=0, fetch ignored.
- RUN: load_ready=1 constantly; write load_data to load_addr on load_valid.
- Fetch (RUN, fetch_en=1, stall=0, flush=0): fault if pc[1:0]≠0 or pc[WIDTH-1:2]≥DEPTH; faulted → instruction=NOP, fault=1, instr_valid=1; else instruction=word[pc[ADDR_W+1:2]], fault=0, instr_valid=1.
- fetch_en=0, no stall/flush: instr_valid=0, fault=0, instruction holds.
- stall=1: all outputs hold.
- flush=1: overrides stall and fetch; next outputs instruction=NOP, instr_valid=0, fault=0.
- Load and fetch to same word in same cycle: fetch returns old content (read-before-write).
- Reset mid-CLEAR or mid-RUN: returns to CLEAR from clr_cnt=0; all previously loaded words are lost.

## Timing
- Reset values: instruction=0, instr_valid=0, fault=0, load_ready=0, parity_err=0, state=CLEAR.
- CLEAR lasts exactly DEPTH cycles after rst deasserts; load_ready rises on edge DEPTH.
- Fetch latency 1 cycle: pc sampled on edge N, result visible after edge N.
- Load write lands on the accepting edge; visible to fetches sampled on the following edge.
- Throughput: one fetch and one load per cycle.

## Configuration
- IMEM_PARITY_EN defined: array stores WIDTH+1 bits (even parity over data); computed on load and CLEAR writes, checked on fetch; mismatch sets parity_err=1 and fault=1 with instruction forced to NOP, same latency as data; parity_err follows stall/flush rules of fault.
- Undefined: array WIDTH bits, no parity_err port, no check logic.

## Structure
- Package imem_pkg: NOP constant (32'b0), FSM state enum, fault-cause helper function.
- Sub-module imem_array: one write port, one synchronous read port, read-before-write, width WIDTH(+1 with parity). FSM, fault logic and output register live in imem_fetch.

## Test plan
- Release reset → load_ready=0, instr_valid=0 for 128 cycles, then load_ready=1; fetch pc=0x10 → instruction=0x00000000, instr_valid=1, fault=0.
- Load addr 3 data 0x04400800, then fetch pc=0x0C → 0x04400800, instr_valid=1 one cycle later.
- Fetch 0x0C, then stall 3 cycles while pc steps 0x10,0x14,0x18 → instruction stays 0x04400800, instr_valid=1; release → word at 0x18 follows.
- Assert flush with stall=1 → instruction=0, instr_valid=0, fault=0 next cycle.
- Fetch pc=0x202 and pc=0x200 → fault=1, instruction=0, instr_valid=1 each.
- Same cycle load addr 5=0xDEADBEEF and fetch pc=0x14 → old 0x00000000; refetch → 0xDEADBEEF. With IMEM_PARITY_EN, force-flip one stored bit of word 5 → parity_err=1, fault=1.
